// File: rtl/instr_decode_16_if.sv
// instr_decode_16_if
// Bundles the fetch-side word handshake and the ALU-side decoded bundle of
// the 16-bit instruction decode stage.
//   fetch side : iw_valid, iw_data -> decoder ; iw_ready, PC_en <- decoder
//   ALU side   : dec_valid + dec_* bundle -> ALU ; dec_ready <- ALU
// Modports:
//   slave  - the decoder (consumes words, produces the bundle)
//   master - the surrounding fetch/ALU environment
interface instr_decode_16_if;
  logic        iw_valid;
  logic [15:0] iw_data;
  logic        iw_ready;
  logic        PC_en;
  logic        dec_valid;
  logic        dec_ready;
  logic [1:0]  dec_fmt;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_singop;
  logic [2:0]  dec_jcond;
  logic [15:0] dec_joff;
  logic [3:0]  dec_src_reg;
  logic [3:0]  dec_dst_reg;
  logic [1:0]  dec_as;
  logic        dec_ad;
  logic        dec_bw;
  logic [15:0] dec_src_ext;
  logic [15:0] dec_dst_ext;
  logic        dec_illegal;

  modport slave (
    input  iw_valid, iw_data, dec_ready,
    output iw_ready, PC_en, dec_valid, dec_fmt, dec_opcode, dec_singop,
           dec_jcond, dec_joff, dec_src_reg, dec_dst_reg, dec_as, dec_ad,
           dec_bw, dec_src_ext, dec_dst_ext, dec_illegal
  );

  modport master (
    output iw_valid, iw_data, dec_ready,
    input  iw_ready, PC_en, dec_valid, dec_fmt, dec_opcode, dec_singop,
           dec_jcond, dec_joff, dec_src_reg, dec_dst_reg, dec_as, dec_ad,
           dec_bw, dec_src_ext, dec_dst_ext, dec_illegal
  );
endinterface

// File: rtl/instr_decode_16.sv
// instr_decode_16
// Decode stage in front of the 16-bit ALU. Takes instruction words from
// fetch, classifies the first word (Format I / Format II / jump / illegal),
// collects up to two extension words (source first, then destination) and
// presents one registered bundle to the ALU until it is accepted.
// Ports:
//   MCLK - clock, all state on rising edge
//   RST  - synchronous active-high reset
//   bus  - instr_decode_16_if.slave (word handshake, PC_en, decoded bundle)
// Optional feature macro: DEC_ILLEGAL_TRAP_EN
//   defined   : an illegal first word produces a bundle with fmt=11 and
//               dec_illegal=1
//   undefined : an illegal first word is consumed and silently dropped;
//               dec_illegal is tied to 0
module instr_decode_16 (
  input  logic                  MCLK,
  input  logic                  RST,
  instr_decode_16_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_OP      = 2'd0,
    ST_SRC_EXT = 2'd1,
    ST_DST_EXT = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  state_t      state_reg;
  logic        iw_ready_reg;
  logic        dec_valid_reg;
  logic        pc_en_reg;
  logic        need_dst_reg;
  logic [1:0]  fmt_reg;
  logic [3:0]  opcode_reg;
  logic [2:0]  singop_reg;
  logic [2:0]  jcond_reg;
  logic [15:0] joff_reg;
  logic [3:0]  src_reg_reg;
  logic [3:0]  dst_reg_reg;
  logic [1:0]  as_reg;
  logic        ad_reg;
  logic        bw_reg;
  logic [15:0] src_ext_reg;
  logic [15:0] dst_ext_reg;

  // ---------------------------------------------------------------
  // First-word decode (only consumed in ST_OP)
  // ---------------------------------------------------------------
  logic        accept;
  logic        is_jump;
  logic        is_f1;
  logic        is_f2;
  logic        src_mode_ext;
  logic        need_src;
  logic        need_dst;
  logic [3:0]  mode_reg_field;
  logic [1:0]  d_fmt;
  logic [2:0]  d_singop;
  logic [2:0]  d_jcond;
  logic [15:0] d_joff;
  logic [3:0]  d_src;
  logic [3:0]  d_dst;
  logic [1:0]  d_as;
  logic        d_ad;
  logic        d_bw;

  assign accept = bus.iw_valid & iw_ready_reg;

  always_comb begin
    is_jump        = (bus.iw_data[15:13] == 3'b001);
    is_f1          = bus.iw_data[15] | bus.iw_data[14];
    is_f2          = (bus.iw_data[15:10] == 6'b000100) &&
                     (bus.iw_data[9:7] != 3'b111);
    // Format I addresses the source through iw[11:8]; Format II through iw[3:0].
    mode_reg_field = is_f1 ? bus.iw_data[11:8] : bus.iw_data[3:0];
    // Indexed/symbolic/absolute (As=01, not the R3 constant generator) or
    // immediate (As=11 on PC) carry a source extension word.
    src_mode_ext   = ((bus.iw_data[5:4] == 2'b01) && (mode_reg_field != 4'd3)) ||
                     ((bus.iw_data[5:4] == 2'b11) && (mode_reg_field == 4'd0));
    need_src       = (is_f1 && src_mode_ext) ||
                     (is_f2 && (bus.iw_data[9:7] != 3'b110) && src_mode_ext);
    need_dst       = is_f1 && bus.iw_data[7];

    d_fmt    = 2'b11;
    d_singop = 3'd0;
    d_jcond  = 3'd0;
    d_joff   = 16'd0;
    d_src    = 4'd0;
    d_dst    = 4'd0;
    d_as     = 2'd0;
    d_ad     = 1'b0;
    d_bw     = 1'b0;
    if (is_jump) begin
      d_fmt   = 2'b10;
      d_jcond = bus.iw_data[12:10];
      d_joff  = {{5{bus.iw_data[9]}}, bus.iw_data[9:0], 1'b0};
    end else if (is_f1) begin
      d_fmt = 2'b00;
      d_src = bus.iw_data[11:8];
      d_ad  = bus.iw_data[7];
      d_bw  = bus.iw_data[6];
      d_as  = bus.iw_data[5:4];
      d_dst = bus.iw_data[3:0];
    end else if (is_f2) begin
      d_fmt    = 2'b01;
      d_singop = bus.iw_data[9:7];
      d_bw     = bus.iw_data[6];
      d_as     = bus.iw_data[5:4];
      d_src    = bus.iw_data[3:0];
      d_dst    = bus.iw_data[3:0];
    end
  end

`ifdef DEC_ILLEGAL_TRAP_EN
  logic illegal_reg;
  assign bus.dec_illegal = illegal_reg;
`else
  assign bus.dec_illegal = 1'b0;
`endif

  // ---------------------------------------------------------------
  // FSM with registered handshake outputs and bundle
  // ---------------------------------------------------------------
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_reg     <= ST_OP;
      iw_ready_reg  <= 1'b1;
      dec_valid_reg <= 1'b0;
      pc_en_reg     <= 1'b0;
      need_dst_reg  <= 1'b0;
      fmt_reg       <= 2'd0;
      opcode_reg    <= 4'd0;
      singop_reg    <= 3'd0;
      jcond_reg     <= 3'd0;
      joff_reg      <= 16'd0;
      src_reg_reg   <= 4'd0;
      dst_reg_reg   <= 4'd0;
      as_reg        <= 2'd0;
      ad_reg        <= 1'b0;
      bw_reg        <= 1'b0;
      src_ext_reg   <= 16'd0;
      dst_ext_reg   <= 16'd0;
`ifdef DEC_ILLEGAL_TRAP_EN
      illegal_reg   <= 1'b0;
`endif
    end else begin
      pc_en_reg <= accept;
      case (state_reg)
        ST_OP: begin
          if (accept) begin
            if (is_jump || is_f1 || is_f2) begin
              fmt_reg      <= d_fmt;
              opcode_reg   <= bus.iw_data[15:12];
              singop_reg   <= d_singop;
              jcond_reg    <= d_jcond;
              joff_reg     <= d_joff;
              src_reg_reg  <= d_src;
              dst_reg_reg  <= d_dst;
              as_reg       <= d_as;
              ad_reg       <= d_ad;
              bw_reg       <= d_bw;
              src_ext_reg  <= 16'd0;
              dst_ext_reg  <= 16'd0;
              need_dst_reg <= need_dst;
`ifdef DEC_ILLEGAL_TRAP_EN
              illegal_reg  <= 1'b0;
`endif
              if (need_src) begin
                state_reg <= ST_SRC_EXT;
              end else if (need_dst) begin
                state_reg <= ST_DST_EXT;
              end else begin
                state_reg     <= ST_OUT;
                iw_ready_reg  <= 1'b0;
                dec_valid_reg <= 1'b1;
              end
            end else begin
`ifdef DEC_ILLEGAL_TRAP_EN
              fmt_reg       <= 2'b11;
              opcode_reg    <= 4'd0;
              singop_reg    <= 3'd0;
              jcond_reg     <= 3'd0;
              joff_reg      <= 16'd0;
              src_reg_reg   <= 4'd0;
              dst_reg_reg   <= 4'd0;
              as_reg        <= 2'd0;
              ad_reg        <= 1'b0;
              bw_reg        <= 1'b0;
              src_ext_reg   <= 16'd0;
              dst_ext_reg   <= 16'd0;
              need_dst_reg  <= 1'b0;
              illegal_reg   <= 1'b1;
              state_reg     <= ST_OUT;
              iw_ready_reg  <= 1'b0;
              dec_valid_reg <= 1'b1;
`else
              // Word is consumed (PC_en still pulses) and dropped.
              state_reg <= ST_OP;
`endif
            end
          end
        end
        ST_SRC_EXT: begin
          if (accept) begin
            src_ext_reg <= bus.iw_data;
            if (need_dst_reg) begin
              state_reg <= ST_DST_EXT;
            end else begin
              state_reg     <= ST_OUT;
              iw_ready_reg  <= 1'b0;
              dec_valid_reg <= 1'b1;
            end
          end
        end
        ST_DST_EXT: begin
          if (accept) begin
            dst_ext_reg   <= bus.iw_data;
            state_reg     <= ST_OUT;
            iw_ready_reg  <= 1'b0;
            dec_valid_reg <= 1'b1;
          end
        end
        ST_OUT: begin
          // No bypass to ST_OP: a new word is only taken the cycle after.
          if (bus.dec_ready) begin
            state_reg     <= ST_OP;
            iw_ready_reg  <= 1'b1;
            dec_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_OP;
          iw_ready_reg  <= 1'b1;
          dec_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iw_ready    = iw_ready_reg;
  assign bus.PC_en       = pc_en_reg;
  assign bus.dec_valid   = dec_valid_reg;
  assign bus.dec_fmt     = fmt_reg;
  assign bus.dec_opcode  = opcode_reg;
  assign bus.dec_singop  = singop_reg;
  assign bus.dec_jcond   = jcond_reg;
  assign bus.dec_joff    = joff_reg;
  assign bus.dec_src_reg = src_reg_reg;
  assign bus.dec_dst_reg = dst_reg_reg;
  assign bus.dec_as      = as_reg;
  assign bus.dec_ad      = ad_reg;
  assign bus.dec_bw      = bw_reg;
  assign bus.dec_src_ext = src_ext_reg;
  assign bus.dec_dst_ext = dst_ext_reg;

endmodule

// File: tb/tb_instr_decode_16.sv
// tb_instr_decode_16
// Directed-vector bench for instr_decode_16. Stimulus pushes the
// hand-computed expected bundle into a queue; a negedge monitor compares the
// presented bundle with the queue head every cycle dec_valid is high and
// pops it on the handshake. The monitor also checks PC_en against the word
// accepts it saw one cycle earlier.
module tb_instr_decode_16;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [3:0]  opcode;
    logic [2:0]  singop;
    logic [2:0]  jcond;
    logic [15:0] joff;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [1:0]  as_f;
    logic        ad;
    logic        bw;
    logic [15:0] sext;
    logic [15:0] dext;
    logic        ill;
  } bundle_t;

  logic MCLK;
  logic RST;
  instr_decode_16_if bus();

  instr_decode_16 dut (
    .MCLK (MCLK),
    .RST  (RST),
    .bus  (bus)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int      checks = 0;
  int      errors = 0;
  bundle_t exp_q[$];
  logic    started = 1'b0;
  logic    acc_prev = 1'b0;
  bundle_t got;

  function automatic bundle_t mk(input logic [1:0] fmt, input logic [3:0] op,
                                 input logic [2:0] sop, input logic [2:0] jc,
                                 input logic [15:0] joff, input logic [3:0] src,
                                 input logic [3:0] dst, input logic [1:0] as_f,
                                 input logic ad, input logic bw,
                                 input logic [15:0] sext, input logic [15:0] dext,
                                 input logic ill);
    bundle_t b;
    b.fmt = fmt; b.opcode = op; b.singop = sop; b.jcond = jc; b.joff = joff;
    b.src = src; b.dst = dst; b.as_f = as_f; b.ad = ad; b.bw = bw;
    b.sext = sext; b.dext = dext; b.ill = ill;
    return b;
  endfunction

  always_comb begin
    got = {bus.dec_fmt, bus.dec_opcode, bus.dec_singop, bus.dec_jcond,
           bus.dec_joff, bus.dec_src_reg, bus.dec_dst_reg, bus.dec_as,
           bus.dec_ad, bus.dec_bw, bus.dec_src_ext, bus.dec_dst_ext,
           bus.dec_illegal};
  end

  // Monitor / scoreboard
  always @(negedge MCLK) begin
    if (started) begin
      checks++;
      if (bus.PC_en !== acc_prev) begin
        errors++;
        $display("FAIL pc_en: got %b expected %b at %0t", bus.PC_en, acc_prev, $time);
      end
      acc_prev <= bus.iw_valid & bus.iw_ready & ~RST;
      if (bus.dec_valid === 1'b1) begin
        checks++;
        if (bus.iw_ready !== 1'b0) begin
          errors++;
          $display("FAIL iw_ready_while_valid: got %b expected 0", bus.iw_ready);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bundle: got %h expected none", got);
        end else begin
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL bundle: got %h expected %h", got, exp_q[0]);
          end
          if (bus.dec_ready === 1'b1) begin
            $display("bundle accepted fmt=%b opcode=%h src_ext=%h dst_ext=%h",
                     got.fmt, got.opcode, got.sext, got.dext);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Present one word and hold it until accepted. Starts/ends at posedge+1.
  task automatic send_word(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    bus.iw_valid = 1'b1;
    bus.iw_data  = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge MCLK);
      if (bus.iw_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge MCLK);
    #1;
    bus.iw_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got iw_ready=0 expected 1 word %h", w);
    end
  endtask

  // Send an instruction of n words with gap idle cycles between words and
  // check dec_valid rises only after the last word.
  task automatic send_instr(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input int n, input int gap,
                            input bit has_exp, input bundle_t e);
    logic [15:0] words [3];
    logic        want;
    words[0] = w0; words[1] = w1; words[2] = w2;
    if (has_exp) exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      send_word(words[i]);
      @(negedge MCLK);
      want = (i == n - 1) && has_exp;
      checks++;
      if (bus.dec_valid !== want) begin
        errors++;
        $display("FAIL dec_valid_timing: got %b expected %b after word %0d", bus.dec_valid, want, i);
      end
      @(posedge MCLK);
      #1;
      if (i != n - 1) begin
        repeat (gap) begin
          @(posedge MCLK);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge MCLK);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  initial begin
    bus.iw_valid  = 1'b0;
    bus.iw_data   = 16'h0000;
    bus.dec_ready = 1'b1;
    RST = 1'b1;
    repeat (2) @(posedge MCLK);
    #1;
    RST = 1'b0;

    // Reset state
    @(negedge MCLK);
    checks++; if (bus.iw_ready !== 1'b1) begin errors++; $display("FAIL reset_iw_ready: got %b expected 1", bus.iw_ready); end
    checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b expected 0", bus.dec_valid); end
    checks++; if (bus.PC_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %b expected 0", bus.PC_en); end
    checks++; if (got !== '0) begin errors++; $display("FAIL reset_fields: got %h expected 0", got); end
    $display("reset checked");
    started = 1'b1;
    @(posedge MCLK);
    #1;

    // MOV R5,R6
    send_instr(16'h4506, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b00, 4'h4, 3'd0, 3'd0, 16'h0, 4'd5, 4'd6, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    wait_drain();

    // MOV #0x1234,2(R7) with 2 idle cycles between words
    send_instr(16'h40B7, 16'h1234, 16'h0002, 3, 2, 1'b1,
               mk(2'b00, 4'h4, 3'd0, 3'd0, 16'h0, 4'd0, 4'd7, 2'b11, 1'b1, 1'b0, 16'h1234, 16'h0002, 1'b0));
    wait_drain();

    // Jumps
    send_instr(16'h3FFF, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b10, 4'h3, 3'd0, 3'd7, 16'hFFFE, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    wait_drain();
    send_instr(16'h2001, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b10, 4'h2, 3'd0, 3'd0, 16'h0002, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    wait_drain();

    // Constant generator R3, As=01: no extension
    send_instr(16'h5316, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b00, 4'h5, 3'd0, 3'd0, 16'h0, 4'd3, 4'd6, 2'b01, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    wait_drain();

    // Destination extension only, BW=1
    send_instr(16'h45C6, 16'hBEEF, 16'h0, 2, 1, 1'b1,
               mk(2'b00, 4'h4, 3'd0, 3'd0, 16'h0, 4'd5, 4'd6, 2'b00, 1'b1, 1'b1, 16'h0, 16'hBEEF, 1'b0));
    wait_drain();

    // Format II RRC 0x10(R5): source extension
    send_instr(16'h1015, 16'h0010, 16'h0, 2, 0, 1'b1,
               mk(2'b01, 4'h1, 3'd0, 3'd0, 16'h0, 4'd5, 4'd5, 2'b01, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0));
    wait_drain();

    // RETI with As=01 on R0: never takes an extension word
    send_instr(16'h1310, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b01, 4'h1, 3'd6, 3'd0, 16'h0, 4'd0, 4'd0, 2'b01, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    wait_drain();

    // Backpressure: hold dec_ready low 5 cycles; monitor re-checks each cycle
    bus.dec_ready = 1'b0;
    send_instr(16'h4506, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b00, 4'h4, 3'd0, 3'd0, 16'h0, 4'd5, 4'd6, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    idle(4);
    checks++;
    if (exp_q.size() != 1) begin errors++; $display("FAIL backpressure_hold: got %0d pending expected 1", exp_q.size()); end
    bus.dec_ready = 1'b1;
    wait_drain();

    // Reset while in SRC_EXT; reset overrides a simultaneous accept
    send_word(16'h40B7);
    RST = 1'b1;
    bus.iw_valid = 1'b1;
    bus.iw_data  = 16'h1234;
    @(posedge MCLK);
    #1;
    RST = 1'b0;
    bus.iw_valid = 1'b0;
    @(negedge MCLK);
    checks++; if (bus.iw_ready !== 1'b1) begin errors++; $display("FAIL rst_src_ext_iw_ready: got %b expected 1", bus.iw_ready); end
    checks++; if (got !== '0) begin errors++; $display("FAIL rst_src_ext_fields: got %h expected 0", got); end
    $display("reset during SRC_EXT checked");
    idle(3);
    // Fresh decode after the discarded instruction
    send_instr(16'h4506, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b00, 4'h4, 3'd0, 3'd0, 16'h0, 4'd5, 4'd6, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    wait_drain();

    // Illegal words
`ifdef DEC_ILLEGAL_TRAP_EN
    send_instr(16'h0000, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b11, 4'h0, 3'd0, 3'd0, 16'h0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1));
    wait_drain();
    send_instr(16'h1380, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b11, 4'h0, 3'd0, 3'd0, 16'h0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1));
    wait_drain();
`else
    send_instr(16'h0000, 16'h0, 16'h0, 1, 0, 1'b0, '0);
    @(negedge MCLK);
    checks++; if (bus.iw_ready !== 1'b1) begin errors++; $display("FAIL illegal_iw_ready: got %b expected 1", bus.iw_ready); end
    @(posedge MCLK);
    #1;
    send_instr(16'h1380, 16'h0, 16'h0, 1, 0, 1'b0, '0);
    idle(3);
    $display("illegal words dropped");
`endif
    // Decoder still in OP after illegal handling
    send_instr(16'h3FFF, 16'h0, 16'h0, 1, 0, 1'b1,
               mk(2'b10, 4'h3, 3'd0, 3'd7, 16'hFFFE, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0));
    wait_drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
